// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int PORT_CORE = 0;
    localparam int PORT_LDR  = 1;
    localparam int STAT_W    = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational 2-way picker: onehot grant from requests, round-robin or
// fixed priority (loader port wins) on conflict.
module arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = 2'b00;
            if (ROUND_ROBIN != 0 && last_gnt) gnt[PORT_CORE] = 1'b1;
            else                              gnt[PORT_LDR]  = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing the unified memory between the core (port 0) and the loader
// (port 1), with lock ownership and optional timeout. Optional stats: MEM_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no owner, per-access arbitration between both ports
// OWN0  | core holds the lock, loader blocked
// OWN1  | loader holds the lock, core blocked
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ROUND_ROBIN  = 1,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  lock_abort,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]     wait_cnt0,
    output logic [STAT_W-1:0]     wait_cnt1,
    output logic [31:0]           grant_cnt
`endif
);

    localparam int TMR_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    arb_state_e            state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [1:0] req, we, lock;
    logic [1:0] own_mask, req_arb, pick, gnt;
    logic       waiting, abort;

    assign req  = {req1, req0};
    assign we   = {we1, we0};
    assign lock = {lock1, lock0};

    always_comb begin
        own_mask = 2'b00;
        case (state_q)
            OWN0:    own_mask[PORT_CORE] = 1'b1;
            OWN1:    own_mask[PORT_LDR]  = 1'b1;
            default: own_mask = 2'b00;
        endcase
        waiting = ((req & ~own_mask) != 2'b00) && (state_q != IDLE);
        abort   = (LOCK_TIMEOUT > 0) && waiting && (timer_q == TMR_LAST);
        // On a timeout the owner is masked out so the waiting port wins this cycle.
        req_arb = abort ? (req & ~own_mask) : req;
    end

    arb_rr_pick #(
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_pick (
        .req      (req_arb),
        .last_gnt (last_gnt_q),
        .gnt      (pick)
    );

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        gnt     = 2'b00;
        if (state_q == IDLE || abort) begin
            gnt     = pick;
            state_d = IDLE;
            if ((gnt & lock) != 2'b00) state_d = gnt[PORT_LDR] ? OWN1 : OWN0;
        end else begin
            gnt = req & own_mask;
            if ((lock & own_mask) == 2'b00) state_d = IDLE;
            else if (waiting && (LOCK_TIMEOUT > 0)) timer_d = timer_q + TMR_W'(1);
        end
        if (reset) gnt = 2'b00;
        lock_abort = abort && !reset;
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt[PORT_CORE]) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt[PORT_LDR]) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
        rvalid_d   = gnt & ~we;
        rdata_d    = (rvalid_d != 2'b00) ? mem_rdata : rdata_q;
        last_gnt_d = gnt[PORT_LDR] ? 1'b1 : (gnt[PORT_CORE] ? 1'b0 : last_gnt_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            timer_q    <= '0;
            rvalid_q   <= 2'b00;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            timer_q    <= timer_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign gnt0    = gnt[PORT_CORE];
    assign gnt1    = gnt[PORT_LDR];
    assign rvalid0 = rvalid_q[PORT_CORE];
    assign rvalid1 = rvalid_q[PORT_LDR];
    assign rdata   = rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] wait_cnt0_q, wait_cnt0_d;
    logic [STAT_W-1:0] wait_cnt1_q, wait_cnt1_d;
    logic [31:0]       grant_cnt_q, grant_cnt_d;

    always_comb begin
        wait_cnt0_d = (req0 && !gnt0) ? sat_inc(wait_cnt0_q) : wait_cnt0_q;
        wait_cnt1_d = (req1 && !gnt1) ? sat_inc(wait_cnt1_q) : wait_cnt1_q;
        grant_cnt_d = grant_cnt_q + {31'd0, (gnt != 2'b00)};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt0_q <= '0;
            wait_cnt1_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            wait_cnt0_q <= wait_cnt0_d;
            wait_cnt1_q <= wait_cnt1_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign wait_cnt0 = wait_cnt0_q;
    assign wait_cnt1 = wait_cnt1_q;
    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: dut A is round-robin with a 3-cycle lock timeout,
// dut B is fixed priority with unlimited lock. Stats checks under MEM_ARB_STATS_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          req0, req1, we0, we1, lock0, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;

    logic [1:0]    g0, g1, rv0, rv1, abrt, mwe;
    logic [DW-1:0] rd     [2];
    logic [AW-1:0] maddr  [2];
    logic [DW-1:0] mwdata [2];
    logic [DW-1:0] mrdata [2];
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   wc0 [2];
    logic [15:0]   wc1 [2];
    logic [31:0]   gc  [2];
`endif

    logic [DW-1:0] mem_env [2][64];

    int checks   = 0;
    int failures = 0;

    // reference model state, one slot per dut
    int            p_rr    [2];
    int            p_lt    [2];
    int            m_owner [2];
    int            m_last  [2];
    int            m_timer [2];
    logic [1:0]    m_rv    [2];
    logic [DW-1:0] m_rd    [2];
    logic [DW-1:0] m_mem   [2][64];

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(1), .LOCK_TIMEOUT(3)
    ) u_dut_a (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(g0[0]), .gnt1(g1[0]), .rvalid0(rv0[0]), .rvalid1(rv1[0]),
        .rdata(rd[0]), .lock_abort(abrt[0]),
        .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_we(mwe[0]), .mem_rdata(mrdata[0])
`ifdef MEM_ARB_STATS_EN
        , .wait_cnt0(wc0[0]), .wait_cnt1(wc1[0]), .grant_cnt(gc[0])
`endif
    );

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROUND_ROBIN(0), .LOCK_TIMEOUT(0)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(g0[1]), .gnt1(g1[1]), .rvalid0(rv0[1]), .rvalid1(rv1[1]),
        .rdata(rd[1]), .lock_abort(abrt[1]),
        .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_we(mwe[1]), .mem_rdata(mrdata[1])
`ifdef MEM_ARB_STATS_EN
        , .wait_cnt0(wc0[1]), .wait_cnt1(wc1[1]), .grant_cnt(gc[1])
`endif
    );

    assign mrdata[0] = mem_env[0][maddr[0][7:2]];
    assign mrdata[1] = mem_env[1][maddr[1][7:2]];

    always @(posedge clk) begin
        if (mwe[0]) mem_env[0][maddr[0][7:2]] = mwdata[0];
        if (mwe[1]) mem_env[1][maddr[1][7:2]] = mwdata[1];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        tick();
        reset = 1;
        set_idle();
        tick();
        reset = 0;
    endtask

    task automatic init_mem();
        logic [DW-1:0] v;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 64; j++) begin
                v = $urandom;
                mem_env[i][j] = v;
                m_mem[i][j]   = v;
            end
            mem_env[i][4] = 32'hDEAD_BEEF;
            m_mem[i][4]   = 32'hDEAD_BEEF;
        end
    endtask

    task automatic model_reset(input int i);
        m_owner[i] = -1;
        m_last[i]  = 1;
        m_timer[i] = 0;
        m_rv[i]    = 2'b00;
        m_rd[i]    = '0;
    endtask

    task automatic test_reset();
        tick();
        reset = 1;
        req0 = 1; we0 = 1; lock0 = 1; addr0 = 32'h40; wdata0 = 32'h1234_5678;
        req1 = 1; we1 = 1; lock1 = 1; addr1 = 32'h44; wdata1 = 32'h9ABC_DEF0;
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if ({g1[i], g0[i]} !== 2'b00) begin failures++; $display("FAIL reset_gnt dut%0d got=%b exp=00", i, {g1[i], g0[i]}); end
            checks++; if ({rv1[i], rv0[i]} !== 2'b00) begin failures++; $display("FAIL reset_rvalid dut%0d got=%b exp=00", i, {rv1[i], rv0[i]}); end
            checks++; if (rd[i] !== '0) begin failures++; $display("FAIL reset_rdata dut%0d got=%h exp=0", i, rd[i]); end
            checks++; if (abrt[i] !== 1'b0) begin failures++; $display("FAIL reset_abort dut%0d got=%b exp=0", i, abrt[i]); end
            checks++; if (mwe[i] !== 1'b0) begin failures++; $display("FAIL reset_mem_we dut%0d got=%b exp=0", i, mwe[i]); end
            checks++; if (maddr[i] !== '0 || mwdata[i] !== '0) begin failures++; $display("FAIL reset_mem_bus dut%0d got=%h/%h exp=0/0", i, maddr[i], mwdata[i]); end
        end
        tick();
        reset = 0;
        set_idle();
    endtask

    task automatic test_single_read();
        do_reset();
        req0 = 1; addr0 = 32'h10;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if ({g1[i], g0[i]} !== 2'b01) begin failures++; $display("FAIL read_gnt dut%0d got=%b exp=01", i, {g1[i], g0[i]}); end
            checks++; if (maddr[i] !== 32'h10 || mwe[i] !== 1'b0) begin failures++; $display("FAIL read_bus dut%0d got=%h/%b exp=10/0", i, maddr[i], mwe[i]); end
        end
        tick();
        set_idle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if ({rv1[i], rv0[i]} !== 2'b01) begin failures++; $display("FAIL read_rvalid dut%0d got=%b exp=01", i, {rv1[i], rv0[i]}); end
            checks++; if (rd[i] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_rdata dut%0d got=%h exp=deadbeef", i, rd[i]); end
        end
        tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if ({rv1[i], rv0[i]} !== 2'b00) begin failures++; $display("FAIL read_rvalid_drop dut%0d got=%b exp=00", i, {rv1[i], rv0[i]}); end
            checks++; if (rd[i] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL read_rdata_hold dut%0d got=%h exp=deadbeef", i, rd[i]); end
        end
    endtask

    task automatic test_conflict();
        logic [1:0] exp_a;
        do_reset();
        req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h14;
        for (int k = 0; k < 4; k++) begin
            exp_a = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++; if ({g1[0], g0[0]} !== exp_a) begin failures++; $display("FAIL conflict_rr cyc%0d got=%b exp=%b", k, {g1[0], g0[0]}, exp_a); end
            checks++; if ({g1[1], g0[1]} !== 2'b10) begin failures++; $display("FAIL conflict_fixed cyc%0d got=%b exp=10", k, {g1[1], g0[1]}); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_lock_burst();
        logic [1:0] exp_g;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            req0 = 1; we0 = 0; addr0 = 32'h10;
            if (k < 3) begin
                req1 = 1; we1 = 1; addr1 = 32'(k * 4); wdata1 = 32'hA000_0000 + 32'(k); lock1 = (k < 2);
            end else begin
                req1 = 0; we1 = 0; lock1 = 0;
            end
            exp_g = (k < 3) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++; if ({g1[1], g0[1]} !== exp_g) begin failures++; $display("FAIL lock_burst_gnt cyc%0d got=%b exp=%b", k, {g1[1], g0[1]}, exp_g); end
            if (k < 3) begin
                checks++; if (maddr[1] !== 32'(k * 4) || mwe[1] !== 1'b1) begin failures++; $display("FAIL lock_burst_bus cyc%0d got=%h/%b exp=%h/1", k, maddr[1], mwe[1], k * 4); end
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_timeout();
        logic [1:0] exp_g;
        do_reset();
        req1 = 1; lock1 = 1; addr1 = 32'h8;
        @(negedge clk);
        checks++; if ({g1[0], g0[0]} !== 2'b10) begin failures++; $display("FAIL timeout_take got=%b exp=10", {g1[0], g0[0]}); end
        tick();
        req1 = 0; lock1 = 1; req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h5555_AAAA;
        for (int k = 1; k <= 3; k++) begin
            exp_g = (k == 3) ? 2'b01 : 2'b00;
            @(negedge clk);
            checks++; if ({g1[0], g0[0]} !== exp_g) begin failures++; $display("FAIL timeout_gnt wait%0d got=%b exp=%b", k, {g1[0], g0[0]}, exp_g); end
            checks++; if (abrt[0] !== (k == 3)) begin failures++; $display("FAIL timeout_abort wait%0d got=%b exp=%b", k, abrt[0], k == 3); end
            checks++; if ({g1[1], g0[1]} !== 2'b00 || abrt[1] !== 1'b0) begin failures++; $display("FAIL nolimit_hold wait%0d got=%b/%b exp=00/0", k, {g1[1], g0[1]}, abrt[1]); end
            if (k == 3) begin
                checks++; if (maddr[0] !== 32'h20 || mwe[0] !== 1'b1 || mwdata[0] !== 32'h5555_AAAA) begin failures++; $display("FAIL timeout_bus got=%h/%b/%h exp=20/1/5555aaaa", maddr[0], mwe[0], mwdata[0]); end
            end
            tick();
        end
        req0 = 0; we0 = 0;
        @(negedge clk);
        checks++; if (abrt[0] !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b exp=0", abrt[0]); end
        tick();
        set_idle();
    endtask

    task automatic test_reset_mid_read();
        do_reset();
        req0 = 1; lock0 = 1; addr0 = 32'h10;
        @(negedge clk);
        checks++; if (g0 !== 2'b11) begin failures++; $display("FAIL midread_gnt got=%b exp=11", g0); end
        tick();
        reset = 1;
        set_idle();
        tick();
        reset = 0;
        req1 = 1; addr1 = 32'h14;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++; if ({rv1[i], rv0[i]} !== 2'b00) begin failures++; $display("FAIL midread_rvalid dut%0d got=%b exp=00", i, {rv1[i], rv0[i]}); end
            checks++; if (rd[i] !== '0) begin failures++; $display("FAIL midread_rdata dut%0d got=%h exp=0", i, rd[i]); end
            checks++; if ({g1[i], g0[i]} !== 2'b10) begin failures++; $display("FAIL midread_owner_clear dut%0d got=%b exp=10", i, {g1[i], g0[i]}); end
        end
        tick();
        set_idle();
    endtask

    task automatic test_random(input int n);
        logic [1:0]    r, w, l, exp_g;
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        logic          rst, ab, ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        int            g, o, x, nowner;
        init_mem();
        do_reset();
        for (int i = 0; i < 2; i++) model_reset(i);
        for (int k = 0; k < n; k++) begin
            rst = ($urandom_range(0, 39) == 0);
            r = 2'($urandom_range(0, 3));
            w = 2'($urandom_range(0, 3));
            l = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                a[p] = 32'($urandom_range(0, 63)) << 2;
                d[p] = $urandom;
            end
            reset = rst;
            req0 = r[0]; req1 = r[1]; we0 = w[0]; we1 = w[1]; lock0 = l[0]; lock1 = l[1];
            addr0 = a[0]; addr1 = a[1]; wdata0 = d[0]; wdata1 = d[1];
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                g = -1;
                ab = 1'b0;
                if (!rst) begin
                    if (m_owner[i] < 0) begin
                        if (r == 2'b11) g = (p_rr[i] != 0) ? 1 - m_last[i] : 1;
                        else if (r[0])  g = 0;
                        else if (r[1])  g = 1;
                    end else begin
                        o = m_owner[i];
                        x = 1 - o;
                        if (p_lt[i] > 0 && r[x] && m_timer[i] + 1 >= p_lt[i]) begin
                            ab = 1'b1;
                            g  = x;
                        end else if (r[o]) begin
                            g = o;
                        end
                    end
                end
                exp_g = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
                ewe   = (g >= 0) ? w[g] : 1'b0;
                ea    = (g >= 0) ? a[g] : '0;
                ed    = (g >= 0) ? d[g] : '0;
                checks++; if ({g1[i], g0[i]} !== exp_g) begin failures++; $display("FAIL rnd_gnt dut%0d cyc%0d got=%b exp=%b", i, k, {g1[i], g0[i]}, exp_g); end
                checks++; if ({rv1[i], rv0[i]} !== m_rv[i]) begin failures++; $display("FAIL rnd_rvalid dut%0d cyc%0d got=%b exp=%b", i, k, {rv1[i], rv0[i]}, m_rv[i]); end
                checks++; if (rd[i] !== m_rd[i]) begin failures++; $display("FAIL rnd_rdata dut%0d cyc%0d got=%h exp=%h", i, k, rd[i], m_rd[i]); end
                checks++; if (abrt[i] !== ab) begin failures++; $display("FAIL rnd_abort dut%0d cyc%0d got=%b exp=%b", i, k, abrt[i], ab); end
                checks++; if (mwe[i] !== ewe) begin failures++; $display("FAIL rnd_mem_we dut%0d cyc%0d got=%b exp=%b", i, k, mwe[i], ewe); end
                checks++; if (maddr[i] !== ea) begin failures++; $display("FAIL rnd_mem_addr dut%0d cyc%0d got=%h exp=%h", i, k, maddr[i], ea); end
                checks++; if (mwdata[i] !== ed) begin failures++; $display("FAIL rnd_mem_wdata dut%0d cyc%0d got=%h exp=%h", i, k, mwdata[i], ed); end
                if (rst) begin
                    model_reset(i);
                end else begin
                    m_rv[i] = 2'b00;
                    if (g >= 0) begin
                        m_last[i] = g;
                        if (w[g]) m_mem[i][a[g][7:2]] = d[g];
                        else begin
                            m_rv[i][g] = 1'b1;
                            m_rd[i]    = m_mem[i][a[g][7:2]];
                        end
                    end
                    if (m_owner[i] < 0 || ab) nowner = (g >= 0 && l[g]) ? g : -1;
                    else                      nowner = l[m_owner[i]] ? m_owner[i] : -1;
                    if (m_owner[i] >= 0 && !ab && nowner == m_owner[i] && r[1 - m_owner[i]]) m_timer[i]++;
                    else m_timer[i] = 0;
                    m_owner[i] = nowner;
                end
            end
            tick();
        end
        reset = 0;
        set_idle();
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h14;
        repeat (5) tick();
        set_idle();
        @(negedge clk);
        checks++; if (wc0[1] !== 16'd5) begin failures++; $display("FAIL stats_wait0 got=%0d exp=5", wc0[1]); end
        checks++; if (wc1[1] !== 16'd0) begin failures++; $display("FAIL stats_wait1 got=%0d exp=0", wc1[1]); end
        checks++; if (gc[1] !== 32'd5) begin failures++; $display("FAIL stats_grants got=%0d exp=5", gc[1]); end
        tick();
        req0 = 1; req1 = 1;
        repeat (70000) @(posedge clk);
        #1;
        set_idle();
        @(negedge clk);
        checks++; if (wc0[1] !== 16'hFFFF) begin failures++; $display("FAIL stats_sat got=%h exp=ffff", wc0[1]); end
        checks++; if (gc[1] !== 32'd70005) begin failures++; $display("FAIL stats_grants_long got=%0d exp=70005", gc[1]); end
        tick();
    endtask
`endif

    initial begin
        p_rr  = '{1, 0};
        p_lt  = '{3, 0};
        reset = 1;
        set_idle();
        init_mem();
        test_reset();
        test_single_read();
        test_conflict();
        test_lock_burst();
        test_timeout();
        test_reset_mid_read();
        test_random(600);
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
